// File: rtl/uart_tx_core.sv
// uart_tx_core
// Parametrised UART transmitter running entirely in the clk domain. A baud
// counter produces one bit period every CLK_DIV clocks. Words arrive on a
// valid/ready handshake and are sent as: start bit, DATA_BITS data bits
// (LSB first), an optional parity bit, then STOP_BITS stop bits.
//
// Parameters:
//   CLK_DIV   - clk cycles per serial bit (2..65535)
//   DATA_BITS - payload width (5..9)
//   PARITY    - 0 none, 1 odd, 2 even
//   STOP_BITS - 1 or 2
//
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset
//   tx_data  in   word to send, latched on accept
//   tx_valid in   tx_data is valid
//   tx_ready out  high while idle; accept = tx_valid && tx_ready at an edge
//   tx_done  out  one-cycle pulse on the edge the frame completes
//   tx       out  registered serial line, idles high

module uart_tx_core #(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 tx
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
            $error("uart_tx_core: CLK_DIV must be in 2..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_core: DATA_BITS must be in 5..9");
        end
        if (PARITY > 2) begin : g_bad_parity
            $error("uart_tx_core: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_core: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next values
    // ------------------------------------------------------------------
    state_t                 state,    state_nxt;
    logic [DATA_BITS-1:0]   shreg,    shreg_nxt;
    logic [BW-1:0]          bit_cnt,  bit_nxt;
    logic [CW-1:0]          baud_cnt, baud_nxt;
    logic                   par_bit,  par_nxt;
    logic                   tx_q,     tx_nxt;
    logic                   done_q,   done_nxt;
    logic                   baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Parity is computed from the word at accept time so the shift register
    // can be consumed destructively during the data phase.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        return (PARITY == 1) ? ~p : p;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_nxt;
            baud_cnt <= baud_nxt;
            par_bit  <= par_nxt;
            tx_q     <= tx_nxt;
            done_q   <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. tx_nxt is the level for the bit
    // that begins on the coming edge, so tx changes together with state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        baud_nxt  = baud_cnt;
        par_nxt   = par_bit;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;

        if (state != ST_IDLE) begin
            baud_nxt = baud_end ? '0 : baud_cnt + 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (tx_valid) begin
                    state_nxt = ST_START;
                    shreg_nxt = tx_data;
                    par_nxt   = parity_of(tx_data);
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                    tx_nxt    = 1'b0;
                end
            end

            ST_START: begin
                if (baud_end) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                end
            end

            ST_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt = '0;
                        if (PARITY != 0) begin
                            state_nxt = ST_PARITY;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = ST_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
            end

            ST_PARITY: begin
                if (baud_end) begin
                    state_nxt = ST_STOP;
                    bit_nxt   = '0;
                    tx_nxt    = 1'b1;
                end
            end

            ST_STOP: begin
                tx_nxt = 1'b1;
                if (baud_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nxt = ST_IDLE;
                        bit_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                bit_nxt   = '0;
                baud_nxt  = '0;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_ready = (state == ST_IDLE);
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule
